// File: rtl/fifo_pkg.sv
// Shared FIFO types: sticky error flag bundle and sizing limits.
package fifo_pkg;

    localparam int unsigned FIFO_MIN_DEPTH = 2;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage

// File: rtl/fifo_v4.sv
// Synchronous flop-array FIFO with optional fall-through, runtime almost-full/empty
// thresholds and sticky overflow/underflow flags.
module fifo_v4
    import fifo_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = $clog2(DEPTH),
    parameter int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 testmode_i,
    input  logic [CNT_WIDTH-1:0] alm_full_th_i,
    input  logic [CNT_WIDTH-1:0] alm_empty_th_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 alm_full_o,
    output logic                 alm_empty_o,
    output logic [CNT_WIDTH-1:0] usage_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    input  logic                 err_clr_i,
    input  dtype                 data_i,
    input  logic                 push_i,
    output dtype                 data_o,
    input  logic                 pop_i
);

    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [ADDR_DEPTH-1:0] wptr_q, wptr_d;
    logic [ADDR_DEPTH-1:0] rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  usage_q, usage_d;
    fifo_err_t             err_q, err_d;
    dtype                  mem_q [DEPTH];

    logic full, empty, bypass;
    logic push_acc, pop_acc;
    logic ovf_evt, unf_evt;
    logic unused_testmode;

    assign unused_testmode = testmode_i;

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_DEPTH'(1);
    endfunction

    assign full  = (usage_q == FULL_CNT);
    assign empty = (usage_q == '0);

    // Fall-through push+pop on an empty FIFO passes straight through without touching storage.
    assign bypass   = FALL_THROUGH && empty && push_i && pop_i;
    assign push_acc = push_i && !full && !bypass;
    assign pop_acc  = pop_i && !empty;
    assign ovf_evt  = push_i && full;
    assign unf_evt  = pop_i && empty && !bypass;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        usage_d = usage_q;
        err_d   = err_q;
        if (err_clr_i) begin
            err_d = '0;
        end
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            usage_d = '0;
        end else begin
            if (push_acc) wptr_d = ptr_inc(wptr_q);
            if (pop_acc)  rptr_d = ptr_inc(rptr_q);
            if (push_acc && !pop_acc) begin
                usage_d = usage_q + CNT_WIDTH'(1);
            end else if (!push_acc && pop_acc) begin
                usage_d = usage_q - CNT_WIDTH'(1);
            end
            // New error events win over a same-cycle clear.
            if (ovf_evt) err_d.overflow  = 1'b1;
            if (unf_evt) err_d.underflow = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
            err_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            usage_q <= usage_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_acc && !flush_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign usage_o     = usage_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign overflow_o  = err_q.overflow;
    assign underflow_o = err_q.underflow;
    assign alm_full_o  = (usage_q >= alm_full_th_i);
    assign alm_empty_o = (usage_q <= alm_empty_th_i);
    assign data_o      = (FALL_THROUGH && empty) ? data_i : mem_q[rptr_q];

    a_depth_min: assert property (@(posedge clk_i) DEPTH >= FIFO_MIN_DEPTH);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_acc && full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_acc && empty));

endmodule

// File: tb/tb_fifo_v4.sv
// Bench for fifo_v4: queue-based reference model with per-cycle compare, directed
// corner cases, randomized traffic, and a fall-through instance.
module tb_fifo_v4;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEP   = 4;
    localparam int unsigned CW    = $clog2(DEP + 1);

    logic          clk, rst_n;
    logic          flush, testmode, err_clr;
    logic [CW-1:0] afth, aeth;
    logic          push, pop;
    logic [DW-1:0] din, dout;
    logic          full, empty, afull, aempty, ovf, unf;
    logic [CW-1:0] usage;

    logic          ft_push, ft_pop;
    logic [DW-1:0] ft_din, ft_dout;
    logic          ft_full, ft_empty, ft_afull, ft_aempty, ft_ovf, ft_unf;
    logic [CW-1:0] ft_usage;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf, m_unf;
    bit            cmp_en = 0;

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
        .alm_full_th_i(afth), .alm_empty_th_i(aeth),
        .full_o(full), .empty_o(empty), .alm_full_o(afull), .alm_empty_o(aempty),
        .usage_o(usage), .overflow_o(ovf), .underflow_o(unf), .err_clr_i(err_clr),
        .data_i(din), .push_i(push), .data_o(dout), .pop_i(pop)
    );

    fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(DW), .DEPTH(DEP)) dut_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .testmode_i(testmode),
        .alm_full_th_i(afth), .alm_empty_th_i(aeth),
        .full_o(ft_full), .empty_o(ft_empty), .alm_full_o(ft_afull), .alm_empty_o(ft_aempty),
        .usage_o(ft_usage), .overflow_o(ft_ovf), .underflow_o(ft_unf), .err_clr_i(1'b0),
        .data_i(ft_din), .push_i(ft_push), .data_o(ft_dout), .pop_i(ft_pop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a queue of accepted words plus two sticky bits.
    task automatic model_update();
        bit was_full, was_empty;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        if (err_clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (flush) begin
            mq.delete();
        end else begin
            was_full  = (mq.size() == DEP);
            was_empty = (mq.size() == 0);
            if (push && was_full)  m_ovf = 1;
            if (pop && was_empty)  m_unf = 1;
            if (pop && !was_empty) void'(mq.pop_front());
            if (push && !was_full) mq.push_back(din);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("usage", 32'(usage), 32'(mq.size()));
            chk("full", 32'(full), 32'(mq.size() == DEP));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("alm_full", 32'(afull), 32'(mq.size() >= int'(afth)));
            chk("alm_empty", 32'(aempty), 32'(mq.size() <= int'(aeth)));
            chk("overflow", 32'(ovf), 32'(m_ovf));
            chk("underflow", 32'(unf), 32'(m_unf));
            if (mq.size() > 0) chk("data", 32'(dout), 32'(mq[0]));
        end
    end

    task automatic step(input bit ps, input bit pp, input logic [DW-1:0] d,
                        input bit fl, input bit clr);
        push = ps; pop = pp; din = d; flush = fl; err_clr = clr;
        @(posedge clk);
        model_update();
        #1;
        push = 0; pop = 0; flush = 0; err_clr = 0;
    endtask

    logic [DW-1:0] pat [4];
    logic          exp_ae [4];
    logic          exp_af [4];

    initial begin
        pat    = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_ae = '{1'b1, 1'b0, 1'b0, 1'b0};
        exp_af = '{1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 0; flush = 0; testmode = 0; err_clr = 0;
        push = 0; pop = 0; din = 8'h00;
        ft_push = 0; ft_pop = 0; ft_din = 8'h00;
        afth = 0; aeth = 0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_data", 32'(dout), 32'd0);
        chk("rst_alm_empty", 32'(aempty), 32'd1);
        chk("rst_alm_full_th0", 32'(afull), 32'd1);
        cmp_en = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1; afth = 3; aeth = 1;

        // Fill to full, tracking almost flags at each level.
        #1;
        chk("ae_at0", 32'(aempty), 32'd1);
        chk("af_at0", 32'(afull), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, pat[i], 0, 0);
            chk("fill_usage", 32'(usage), 32'(i + 1));
            chk("fill_ae", 32'(aempty), 32'(exp_ae[i]));
            chk("fill_af", 32'(afull), 32'(exp_af[i]));
        end
        chk("full_after4", 32'(full), 32'd1);

        step(1, 0, 8'h55, 0, 0);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_usage", 32'(usage), 32'd4);

        for (int i = 0; i < 4; i++) begin
            chk("pop_data", 32'(dout), 32'(pat[i]));
            step(0, 1, 8'h00, 0, 0);
            chk("pop_usage", 32'(usage), 32'(3 - i));
        end
        chk("empty_end", 32'(empty), 32'd1);

        step(0, 0, 8'h00, 0, 1);
        chk("ovf_clr", 32'(ovf), 32'd0);

        step(0, 1, 8'h00, 0, 0);
        chk("unf_set", 32'(unf), 32'd1);
        step(0, 1, 8'h00, 0, 1);
        chk("unf_beats_clr", 32'(unf), 32'd1);
        step(0, 0, 8'h00, 0, 1);
        chk("unf_clr", 32'(unf), 32'd0);

        // Flush with a same-cycle push; sticky flag must survive.
        step(0, 1, 8'h00, 0, 0);
        step(1, 0, 8'hA1, 0, 0);
        step(1, 0, 8'hA2, 0, 0);
        step(1, 0, 8'hA3, 0, 0);
        chk("pre_flush_usage", 32'(usage), 32'd3);
        step(1, 0, 8'hA4, 1, 0);
        chk("flush_usage", 32'(usage), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_unf_kept", 32'(unf), 32'd1);
        step(0, 0, 8'h00, 0, 1);

        // Asynchronous reset in the middle of a cycle with two entries stored.
        step(1, 0, 8'h66, 0, 0);
        step(1, 0, 8'h77, 0, 0);
        chk("pre_rst_data", 32'(dout), 32'h66);
        #2;
        rst_n = 0;
        model_update();
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_usage", 32'(usage), 32'd0);
        chk("arst_data", 32'(dout), 32'd0);
        chk("arst_alm_empty", 32'(aempty), 32'd1);
        chk("arst_alm_full", 32'(afull), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        step(1, 0, 8'h88, 0, 0);
        chk("post_rst_data", 32'(dout), 32'h88);
        chk("post_rst_usage", 32'(usage), 32'd1);

        // Randomized traffic with alternating fill/drain bias.
        for (int i = 0; i < 600; i++) begin
            bit ps, pp, fl, clr;
            int bias;
            if (i % 25 == 0) begin
                afth = CW'($urandom_range(0, 7));
                aeth = CW'($urandom_range(0, 7));
            end
            bias = ((i / 40) % 2 == 0) ? 3 : 1;
            ps  = ($urandom_range(0, 3) < bias);
            pp  = ($urandom_range(0, 3) < (4 - bias));
            fl  = ($urandom_range(0, 59) == 0);
            clr = !fl && ($urandom_range(0, 19) == 0);
            step(ps, pp, DW'($urandom), fl, clr);
        end
        cmp_en = 0;

        // Fall-through instance: bypass on empty, then a normal push/pop.
        afth = 3; aeth = 1;
        ft_din = 8'hA5; ft_push = 1; ft_pop = 1;
        #1;
        chk("ft_bypass_data", 32'(ft_dout), 32'hA5);
        @(posedge clk);
        #1;
        ft_push = 0; ft_pop = 0; ft_din = 8'h00;
        chk("ft_bypass_usage", 32'(ft_usage), 32'd0);
        chk("ft_bypass_unf", 32'(ft_unf), 32'd0);
        chk("ft_bypass_empty", 32'(ft_empty), 32'd1);
        ft_din = 8'h3C; ft_push = 1;
        #1;
        chk("ft_push_same_cycle", 32'(ft_dout), 32'h3C);
        @(posedge clk);
        #1;
        ft_push = 0; ft_din = 8'h99;
        chk("ft_push_usage", 32'(ft_usage), 32'd1);
        chk("ft_stored_data", 32'(ft_dout), 32'h3C);
        ft_pop = 1;
        @(posedge clk);
        #1;
        chk("ft_pop_usage", 32'(ft_usage), 32'd0);
        @(posedge clk);
        #1;
        ft_pop = 0;
        chk("ft_real_underflow", 32'(ft_unf), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
